idma_lite_req_arbiter: RTL and testbench

Shares one AXI-Lite iDMA backend between `NumReq` frontends. It round-robin arbitrates their 1D transfer requests onto the backend request port and records the winner's index in an in-order ownership FIFO. It then routes each backend response back to the requester that issued the transfer. It sits between the register/descriptor frontends and the AXI-Lite backend synthesis wrapper.

---
 rtl/idma_lite_req_arbiter_pkg.sv | 24 ++
 rtl/idma_lite_req_arbiter_if.sv | 36 +++
 rtl/idma_lite_req_arbiter_fifo.sv | 48 ++++
 rtl/idma_lite_req_arbiter.sv | 95 +++++++++
 tb/tb_idma_lite_req_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/idma_lite_req_arbiter_pkg.sv
// Shared types for the iDMA-lite request arbiter slice.
//   idma_req_t : 1D transfer request (length, source/destination address, options)
//   idma_rsp_t : 1D transfer response (last, error, payload)
//   idx_width  : index width helper that never returns 0
package idma_lite_req_arbiter_pkg;

  typedef struct packed {
    logic [31:0] length;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [3:0]  opt;
  } idma_req_t;

  typedef struct packed {
    logic        last;
    logic        error;
    logic [31:0] payload;
  } idma_rsp_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/idma_lite_req_arbiter_if.sv
// Bus bundle between N frontends, the arbiter and one AXI-Lite iDMA backend.
//   master : arbiter side (drives grants, routed responses, backend request)
//   slave  : frontends + backend + status observer side
interface idma_lite_req_arbiter_if
  import idma_lite_req_arbiter_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned CntWidth = 4
);
  logic      [NumReq-1:0] req_valid_i;
  logic      [NumReq-1:0] req_ready_o;
  idma_req_t [NumReq-1:0] req_i;
  logic      [NumReq-1:0] rsp_valid_o;
  logic      [NumReq-1:0] rsp_ready_i;
  idma_rsp_t              rsp_o;
  idma_req_t              be_req_o;
  logic                   be_req_valid_o;
  logic                   be_req_ready_i;
  idma_rsp_t              be_rsp_i;
  logic                   be_rsp_valid_i;
  logic                   be_rsp_ready_o;
  logic [CntWidth-1:0]    outstanding_o;
  logic                   busy_o;

  modport master (
    input  req_valid_i, req_i, rsp_ready_i, be_req_ready_i, be_rsp_i, be_rsp_valid_i,
    output req_ready_o, rsp_valid_o, rsp_o, be_req_o, be_req_valid_o, be_rsp_ready_o,
           outstanding_o, busy_o
  );

  modport slave (
    output req_valid_i, req_i, rsp_ready_i, be_req_ready_i, be_rsp_i, be_rsp_valid_i,
    input  req_ready_o, rsp_valid_o, rsp_o, be_req_o, be_req_valid_o, be_rsp_ready_o,
           outstanding_o, busy_o
  );
endinterface

// File: rtl/idma_lite_req_arbiter_fifo.sv
// In-order ownership FIFO, no fall-through: a pushed entry becomes visible
// at data_o on the cycle after the push.
//   clk_i/rst_i : clock, async active-high reset
//   push_i/data_i : write one entry (caller guarantees not full)
//   pop_i         : drop head entry (caller guarantees not empty)
//   data_o/empty_o: head entry and empty flag
module idma_lite_req_arbiter_fifo
  import idma_lite_req_arbiter_pkg::*;
#(
  parameter int unsigned DataWidth = 2,
  parameter int unsigned Depth     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 empty_o
);
  localparam int unsigned PtrWidth = idx_width(Depth);
  localparam int unsigned UseWidth = $clog2(Depth + 1);

  logic [Depth-1:0][DataWidth-1:0] mem;
  logic [PtrWidth-1:0]             wr_ptr, rd_ptr;
  logic [UseWidth-1:0]             usage_q;

  assign data_o  = mem[rd_ptr];
  assign empty_o = (usage_q == '0);

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usage_q <= '0;
    end else begin
      // Depth need not be a power of two, so wrap explicitly.
      if (push_i) wr_ptr <= (wr_ptr == PtrWidth'(Depth - 1)) ? '0 : wr_ptr + PtrWidth'(1);
      if (pop_i)  rd_ptr <= (rd_ptr == PtrWidth'(Depth - 1)) ? '0 : rd_ptr + PtrWidth'(1);
      if (push_i && !pop_i)      usage_q <= usage_q + UseWidth'(1);
      else if (pop_i && !push_i) usage_q <= usage_q - UseWidth'(1);
    end
  end
endmodule

// File: rtl/idma_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite iDMA backend between NumReq
// frontends. Winners are queued in an ownership FIFO so each backend
// response is routed back to the frontend that issued the transfer.
//   clk_i/rst_i : clock, async active-high reset
//   bus         : frontend request/response, backend request/response, status
module idma_lite_req_arbiter
  import idma_lite_req_arbiter_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned MaxOutstanding = 8
) (
  input logic                    clk_i,
  input logic                    rst_i,
  idma_lite_req_arbiter_if.master bus
);
  localparam int unsigned IdxWidth = idx_width(NumReq);
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  logic [IdxWidth-1:0] rr_q, lock_idx_q, rr_idx, win_idx, cand, owner;
  logic                lock_q, found, any_valid, can_grant, req_hs, rsp_hs, fifo_empty;
  logic [CntWidth-1:0] cnt_q;

  // Leading-one search starting at rr_q with wrap.
  always_comb begin
    rr_idx = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      cand = IdxWidth'((int'(rr_q) + i) % NumReq);
      if (!found && bus.req_valid_i[cand]) begin
        found  = 1'b1;
        rr_idx = cand;
      end
    end
  end

  // A stalled grant is pinned so the backend payload cannot change under it.
  assign win_idx   = lock_q ? lock_idx_q : rr_idx;
  assign any_valid = |bus.req_valid_i;
  // Only registered state gates the grant: a pop this cycle does not help,
  // which keeps the response inputs out of the request path.
  assign can_grant = (cnt_q < CntWidth'(MaxOutstanding));
  assign req_hs    = bus.be_req_valid_o && bus.be_req_ready_i;
  assign rsp_hs    = bus.be_rsp_valid_i && bus.be_rsp_ready_o;

  always_comb begin
    bus.be_req_valid_o = any_valid && can_grant;
    bus.be_req_o       = bus.req_i[win_idx];
    bus.req_ready_o    = '0;
    if (req_hs) bus.req_ready_o[win_idx] = 1'b1;
    bus.rsp_o          = bus.be_rsp_i;
    bus.rsp_valid_o    = '0;
    if (bus.be_rsp_valid_i && !fifo_empty) bus.rsp_valid_o[owner] = 1'b1;
    bus.be_rsp_ready_o = bus.rsp_ready_i[owner] && !fifo_empty;
    bus.outstanding_o  = cnt_q;
    bus.busy_o         = (cnt_q != '0) || bus.be_req_valid_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      if (req_hs) begin
        rr_q   <= (win_idx == IdxWidth'(NumReq - 1)) ? '0 : win_idx + IdxWidth'(1);
        lock_q <= 1'b0;
      end else if (bus.be_req_valid_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= win_idx;
      end
      if (req_hs && !rsp_hs)      cnt_q <= cnt_q + CntWidth'(1);
      else if (rsp_hs && !req_hs) cnt_q <= cnt_q - CntWidth'(1);
    end
  end

  idma_lite_req_arbiter_fifo #(
    .DataWidth (IdxWidth),
    .Depth     (MaxOutstanding)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (req_hs),
    .data_i  (win_idx),
    .pop_i   (rsp_hs),
    .data_o  (owner),
    .empty_o (fifo_empty)
  );

  // A response with nothing outstanding has no owner and is dropped.
  a_rsp_owner : assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.be_rsp_valid_i && fifo_empty))
    else $error("backend response with no outstanding transfer");
endmodule

// File: tb/tb_idma_lite_req_arbiter.sv
module tb_idma_lite_req_arbiter;
  import idma_lite_req_arbiter_pkg::*;

  logic clk, rst;
  int   errors = 0;
  int   checks = 0;

  idma_lite_req_arbiter_if #(.NumReq(4), .CntWidth(4)) ifa ();
  idma_lite_req_arbiter_if #(.NumReq(4), .CntWidth(2)) ifb ();

  idma_lite_req_arbiter #(.NumReq(4), .MaxOutstanding(8)) dut_a (
    .clk_i (clk), .rst_i (rst), .bus (ifa.master));
  idma_lite_req_arbiter #(.NumReq(4), .MaxOutstanding(2)) dut_b (
    .clk_i (clk), .rst_i (rst), .bus (ifb.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic idma_req_t mk_req(input int k);
    idma_req_t r;
    r.length   = 32'h100 + k;
    r.src_addr = 32'hA000_0000 + k;
    r.dst_addr = 32'hB000_0000 + k;
    r.opt      = 4'(k);
    return r;
  endfunction

  function automatic idma_rsp_t mk_rsp(input int k);
    idma_rsp_t r;
    r.last    = 1'b1;
    r.error   = (k % 2) == 1;
    r.payload = 32'hC0DE_0000 + k;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w1[4];
    int w4[3];
    w1 = '{0, 2, 0, 2};
    w4 = '{3, 1, 3};

    rst = 1'b1;
    ifa.req_valid_i = '0; ifa.rsp_ready_i = '0; ifa.be_req_ready_i = 1'b0;
    ifa.be_rsp_valid_i = 1'b0; ifa.be_rsp_i = '0;
    ifb.req_valid_i = '0; ifb.rsp_ready_i = '0; ifb.be_req_ready_i = 1'b0;
    ifb.be_rsp_valid_i = 1'b0; ifb.be_rsp_i = '0;
    for (int k = 0; k < 4; k++) begin
      ifa.req_i[k] = mk_req(k);
      ifb.req_i[k] = mk_req(k);
    end
    #12;
    chk("rst_req_ready", ifa.req_ready_o, 4'b0000);
    chk("rst_rsp_valid", ifa.rsp_valid_o, 4'b0000);
    chk("rst_be_req_valid", ifa.be_req_valid_o, 1'b0);
    chk("rst_be_rsp_ready", ifa.be_rsp_ready_o, 1'b0);
    chk("rst_outstanding", ifa.outstanding_o, 4'd0);
    chk("rst_busy", ifa.busy_o, 1'b0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Requesters 0 and 2 alternate with the backend always ready.
    ifa.req_valid_i = 4'b0101; ifa.be_req_ready_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("rr_grant", ifa.req_ready_o, 4'b0001 << w1[n]);
      chk("rr_be_req", ifa.be_req_o, mk_req(w1[n]));
      tick();
      chk("rr_outstanding", ifa.outstanding_o, 4'(n + 1));
    end
    ifa.req_valid_i = 4'b0000;
    #1;
    chk("idle_be_req_valid", ifa.be_req_valid_o, 1'b0);
    chk("busy_outstanding", ifa.busy_o, 1'b1);

    // Drain: owners come back 0,2,0,2.
    ifa.rsp_ready_i = 4'b1111; ifa.be_rsp_valid_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      ifa.be_rsp_i = mk_rsp(n);
      #1;
      chk("drain_rsp_valid", ifa.rsp_valid_o, 4'b0001 << w1[n]);
      chk("drain_be_rsp_ready", ifa.be_rsp_ready_o, 1'b1);
      chk("drain_rsp_o", ifa.rsp_o, mk_rsp(n));
      tick();
    end
    ifa.be_rsp_valid_i = 1'b0;
    #1;
    chk("drain_outstanding", ifa.outstanding_o, 4'd0);
    chk("drain_busy", ifa.busy_o, 1'b0);
    chk("empty_be_rsp_ready", ifa.be_rsp_ready_o, 1'b0);

    // rr_q is 3. Requester 1 stalls 3 cycles; requester 0 joins meanwhile.
    ifa.req_valid_i = 4'b0010; ifa.be_req_ready_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if (n == 1) ifa.req_valid_i = 4'b0011;
      #1;
      chk("lock_be_req_valid", ifa.be_req_valid_o, 1'b1);
      chk("lock_be_req", ifa.be_req_o, mk_req(1));
      chk("lock_req_ready", ifa.req_ready_o, 4'b0000);
      tick();
    end
    ifa.be_req_ready_i = 1'b1;
    #1;
    chk("lock_release_grant", ifa.req_ready_o, 4'b0010);
    tick();
    chk("lock_outstanding", ifa.outstanding_o, 4'd1);
    ifa.req_valid_i = 4'b0001;
    #1;
    chk("after_lock_grant", ifa.req_ready_o, 4'b0001);
    tick();
    ifa.req_valid_i = 4'b0000;

    // Owner 1 at head holds rsp_ready low for 2 cycles.
    ifa.be_rsp_valid_i = 1'b1; ifa.rsp_ready_i = 4'b1101; ifa.be_rsp_i = mk_rsp(7);
    for (int n = 0; n < 2; n++) begin
      #1;
      chk("hold_rsp_valid", ifa.rsp_valid_o, 4'b0010);
      chk("hold_be_rsp_ready", ifa.be_rsp_ready_o, 1'b0);
      tick();
      chk("hold_outstanding", ifa.outstanding_o, 4'd2);
    end
    // Accept from 3 and response to 1 in the same cycle.
    ifa.rsp_ready_i = 4'b1111; ifa.req_valid_i = 4'b1000;
    #1;
    chk("conc_be_rsp_ready", ifa.be_rsp_ready_o, 1'b1);
    chk("conc_grant", ifa.req_ready_o, 4'b1000);
    tick();
    chk("conc_outstanding", ifa.outstanding_o, 4'd2);
    ifa.req_valid_i = 4'b0000;
    #1;
    chk("conc_owner0", ifa.rsp_valid_o, 4'b0001);
    tick();
    chk("conc_owner3", ifa.rsp_valid_o, 4'b1000);
    tick();
    ifa.be_rsp_valid_i = 1'b0;
    chk("conc_drained", ifa.outstanding_o, 4'd0);

    // Accepts from 3,1,3 then routed responses.
    for (int n = 0; n < 3; n++) begin
      ifa.req_valid_i = 4'(1 << w4[n]);
      #1;
      chk("own_grant", ifa.req_ready_o, 4'b0001 << w4[n]);
      tick();
    end
    ifa.req_valid_i = 4'b0000;
    chk("own_outstanding", ifa.outstanding_o, 4'd3);
    ifa.be_rsp_valid_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      ifa.be_rsp_i = mk_rsp(10 + n);
      #1;
      chk("own_rsp_valid", ifa.rsp_valid_o, 4'b0001 << w4[n]);
      chk("own_rsp_o", ifa.rsp_o, mk_rsp(10 + n));
      tick();
    end
    ifa.be_rsp_valid_i = 1'b0;
    chk("own_drained", ifa.outstanding_o, 4'd0);

    // Three outstanding (grants 0,1,2 leave rr_q at 3), then async reset.
    ifa.req_valid_i = 4'b0111;
    tick(); tick(); tick();
    ifa.req_valid_i = 4'b0000;
    chk("pre_rst_outstanding", ifa.outstanding_o, 4'd3);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_outstanding", ifa.outstanding_o, 4'd0);
    chk("async_rst_busy", ifa.busy_o, 1'b0);
    chk("async_rst_rsp_valid", ifa.rsp_valid_o, 4'b0000);
    #1 rst = 1'b0;
    ifa.req_valid_i = 4'b1100;
    #1;
    chk("post_rst_grant", ifa.req_ready_o, 4'b0100);
    tick();
    chk("post_rst_outstanding", ifa.outstanding_o, 4'd1);
    ifa.req_valid_i = 4'b0000;

    // MaxOutstanding=2 instance: third request stalls until a pop lands.
    ifb.req_valid_i = 4'b0001; ifb.be_req_ready_i = 1'b1; ifb.rsp_ready_i = 4'b0001;
    for (int n = 0; n < 2; n++) begin
      #1;
      chk("full_fill_grant", ifb.req_ready_o, 4'b0001);
      tick();
    end
    #1;
    chk("full_be_req_valid", ifb.be_req_valid_o, 1'b0);
    chk("full_req_ready", ifb.req_ready_o, 4'b0000);
    chk("full_outstanding", ifb.outstanding_o, 2'd2);
    chk("full_busy", ifb.busy_o, 1'b1);
    tick();
    ifb.be_rsp_valid_i = 1'b1; ifb.be_rsp_i = mk_rsp(20);
    #1;
    chk("full_pop_be_rsp_ready", ifb.be_rsp_ready_o, 1'b1);
    chk("full_pop_no_grant", ifb.be_req_valid_o, 1'b0);
    tick();
    ifb.be_rsp_valid_i = 1'b0;
    #1;
    chk("full_after_pop_valid", ifb.be_req_valid_o, 1'b1);
    chk("full_after_pop_grant", ifb.req_ready_o, 4'b0001);
    chk("full_after_pop_out", ifb.outstanding_o, 2'd1);
    tick();
    ifb.req_valid_i = 4'b0000;
    chk("full_refill_out", ifb.outstanding_o, 2'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
